// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types and constants for the LFSR obstacle generator.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } gen_state_e;

   localparam logic [3:0] PLAY_STATE_DEF = 4'd3;

   // Maximal-length Fibonacci tap masks for common widths
   localparam logic [3:0]  TAPS_W4  = 4'h9;
   localparam logic [4:0]  TAPS_W5  = 5'h12;
   localparam logic [7:0]  TAPS_W8  = 8'hB8;
   localparam logic [15:0] TAPS_W16 = 16'hB400;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running clock-enable divider; tick pulses every DIVIDER
//               enabled cycles. clr has priority over en.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
   parameter int DIVIDER = 71_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int                 c_cnt_w = $clog2(DIVIDER);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIVIDER - 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
      end
   end

   assign tick = en && (r_cnt == c_last);

endmodule : tick_divider
`default_nettype wire

// File: rtl/lfsr_obstacle_gen.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_obstacle_gen
// Description : Pseudo-random obstacle code generator stepped at a divided
//               rate while the game is in its play state.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_obstacle_gen
   import lfsr_pkg::*;
#(
   parameter int                   WIDTH      = 8,
   parameter logic [WIDTH-1:0]     TAPS       = TAPS_W8,
   parameter logic [WIDTH-1:0]     SEED       = WIDTH'(1),
   parameter int                   OUT_W      = 4,
   parameter int                   DIVIDER    = 71_000_000,
   parameter int                   STATE_W    = 4,
   parameter logic [STATE_W-1:0]   PLAY_STATE = STATE_W'(PLAY_STATE_DEF)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STATE_W-1:0] presente,
   input  logic               pause,
   input  logic               seed_load,
   input  logic [WIDTH-1:0]   seed_in,
   output logic [OUT_W-1:0]   obs_aleo,
   output logic               obs_valid,
   output logic [WIDTH-1:0]   lfsr_state,
   output logic               wrapped
);

   gen_state_e       r_state;
   gen_state_e       w_state_nxt;
   logic             w_run_en;
   logic             w_idle;
   logic             w_tick;
   logic             w_step;
   logic             w_lock;
   logic [WIDTH-1:0] w_lfsr_step;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] r_lfsr;
   logic [WIDTH-1:0] r_cur_seed;
   logic             r_obs_valid;
   logic             r_wrapped;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (presente == PLAY_STATE) w_state_nxt = pause ? ST_HOLD : ST_RUN;
         end
         ST_RUN: begin
            if (presente != PLAY_STATE) w_state_nxt = ST_IDLE;
            else if (pause)             w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (presente != PLAY_STATE) w_state_nxt = ST_IDLE;
            else if (!pause)            w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath follows the state being entered, so a game exit reloads the
   // seed on the very next edge and a pause freezes the count immediately.
   always_comb begin
      w_run_en = 1'b0;
      w_idle   = 1'b0;
      case (w_state_nxt)
         ST_RUN:  w_run_en = 1'b1;
         ST_HOLD: w_run_en = 1'b0;
         default: w_idle   = 1'b1;
      endcase
   end

   tick_divider #(
      .DIVIDER (DIVIDER)
   ) u_tick_divider (
      .clk  (clk),
      .rst  (rst),
      .en   (w_run_en),
      .clr  (w_idle | seed_load),
      .tick (w_tick)
   );

   assign w_lfsr_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
   assign w_load_val  = (seed_in == '0) ? SEED : seed_in;
   assign w_lock      = (r_lfsr == '0);
   assign w_step      = w_tick && !seed_load && !w_lock;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lfsr      <= SEED;
         r_cur_seed  <= SEED;
         r_obs_valid <= 1'b0;
         r_wrapped   <= 1'b0;
      end else begin
         r_obs_valid <= w_step;
         r_wrapped   <= w_step && (w_lfsr_step == r_cur_seed);
         if (seed_load) begin
            r_lfsr     <= w_load_val;
            r_cur_seed <= w_load_val;
         end else if (w_lock || w_idle) begin
            r_lfsr <= r_cur_seed;
         end else if (w_step) begin
            r_lfsr <= w_lfsr_step;
         end
      end
   end

   assign obs_aleo   = r_lfsr[OUT_W-1:0];
   assign obs_valid  = r_obs_valid;
   assign lfsr_state = r_lfsr;
   assign wrapped    = r_wrapped;

endmodule : lfsr_obstacle_gen
`default_nettype wire

// File: tb/tb_lfsr_obstacle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_obstacle_gen
// Description : Self-checking bench for lfsr_obstacle_gen (WIDTH=4, DIVIDER=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_obstacle_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] presente;
   logic       pause;
   logic       seed_load;
   logic [3:0] seed_in;
   logic [3:0] obs_aleo;
   logic       obs_valid;
   logic [3:0] lfsr_state;
   logic       wrapped;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Behavioural model state
   int m_lfsr, m_seed, m_cnt;
   bit m_valid, m_wrap;

   lfsr_obstacle_gen #(
      .WIDTH      (4),
      .TAPS       (4'h9),
      .SEED       (4'h1),
      .OUT_W      (4),
      .DIVIDER    (4),
      .STATE_W    (4),
      .PLAY_STATE (4'd3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .presente   (presente),
      .pause      (pause),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .obs_aleo   (obs_aleo),
      .obs_valid  (obs_valid),
      .lfsr_state (lfsr_state),
      .wrapped    (wrapped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Shift left, feedback = parity of bits 0 and 3
   function automatic int next_val(input int v);
      int fb;
      fb = $countones(v & 9) % 2;
      return ((v * 2) % 16) + fb;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_lfsr = 1; m_seed = 1; m_cnt = 0; m_valid = 0; m_wrap = 0;
      end else begin
         m_valid = 0;
         m_wrap  = 0;
         if (seed_load) begin
            m_seed = (seed_in == 0) ? 1 : int'(seed_in);
            m_lfsr = m_seed;
            m_cnt  = 0;
         end else if (presente != 4'd3) begin
            m_lfsr = m_seed;
            m_cnt  = 0;
         end else if (!pause) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 4) begin
               m_cnt   = 0;
               m_lfsr  = next_val(m_lfsr);
               m_valid = 1;
               m_wrap  = (m_lfsr == m_seed);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_obs_aleo",   int'(obs_aleo),   m_lfsr);
         chk("model_lfsr_state", int'(lfsr_state), m_lfsr);
         chk("model_obs_valid",  int'(obs_valid),  int'(m_valid));
         chk("model_wrapped",    int'(wrapped),    int'(m_wrap));
      end
   end

   initial begin
      int exp_seq [15] = '{3, 7, 15, 14, 13, 10, 5, 11, 6, 12, 9, 2, 4, 8, 1};
      int wraps;
      int wrap_val;

      rst = 1'b0; presente = 4'd0; pause = 1'b0; seed_load = 1'b0; seed_in = 4'd0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("reset_aleo",  int'(obs_aleo),   1);
         chk("reset_valid", int'(obs_valid),  0);
         chk("reset_wrap",  int'(wrapped),    0);
         chk("reset_lfsr",  int'(lfsr_state), 1);
      end

      // Full period
      presente = 4'd3;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i % 4 == 0) begin
            chk("seq_valid", int'(obs_valid), 1);
            chk("seq_value", int'(obs_aleo), exp_seq[i/4-1]);
            chk("seq_wrap",  int'(wrapped), (i == 60) ? 1 : 0);
         end else begin
            chk("seq_gap_valid", int'(obs_valid), 0);
         end
      end

      // Pause after two counted cycles
      repeat (2) @(negedge clk);
      pause = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("pause_valid", int'(obs_valid), 0);
      end
      pause = 1'b0;
      @(negedge clk);
      chk("unpause_early", int'(obs_valid), 0);
      @(negedge clk);
      chk("unpause_valid", int'(obs_valid), 1);
      chk("unpause_value", int'(obs_aleo), 3);

      // Game exit at value E
      repeat (12) @(negedge clk);
      chk("exit_at_e", int'(obs_aleo), 14);
      presente = 4'd2;
      @(negedge clk);
      chk("exit_lfsr",  int'(lfsr_state), 1);
      chk("exit_valid", int'(obs_valid), 0);
      presente = 4'd3;
      repeat (3) @(negedge clk);
      chk("reenter_quiet", int'(obs_valid), 0);
      @(negedge clk);
      chk("reenter_valid", int'(obs_valid), 1);
      chk("reenter_value", int'(obs_aleo), 3);

      // Zero seed maps to SEED
      seed_load = 1'b1; seed_in = 4'h0;
      @(negedge clk);
      seed_load = 1'b0;
      chk("zero_seed_lfsr",  int'(lfsr_state), 1);
      chk("zero_seed_valid", int'(obs_valid), 0);

      // Load A on the tick cycle
      repeat (3) @(negedge clk);
      seed_load = 1'b1; seed_in = 4'hA;
      @(negedge clk);
      seed_load = 1'b0;
      chk("loadA_lfsr",  int'(lfsr_state), 10);
      chk("loadA_valid", int'(obs_valid), 0);
      wraps = 0; wrap_val = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (i == 4) begin
            chk("loadA_first_valid", int'(obs_valid), 1);
            chk("loadA_first_value", int'(obs_aleo), 5);
         end
         if (wrapped) begin
            wraps++;
            wrap_val = int'(obs_aleo);
         end
      end
      chk("loadA_wrap_count", wraps, 1);
      chk("loadA_wrap_value", wrap_val, 10);

      // Mid-run reset
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_lfsr", int'(lfsr_state), 1);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_quiet", int'(obs_valid), 0);
      end
      @(negedge clk);
      chk("midrst_valid", int'(obs_valid), 1);
      chk("midrst_value", int'(obs_aleo), 3);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         presente  = ($urandom_range(0, 9) < 8) ? 4'd3 : 4'($urandom_range(0, 15));
         pause     = ($urandom_range(0, 9) < 2);
         seed_load = ($urandom_range(0, 39) == 0);
         seed_in   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         rst       = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end
      rst = 1'b1; seed_load = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lfsr_obstacle_gen
`default_nettype wire

// File: doc/lfsr_obstacle_gen.md
Name: lfsr_obstacle_gen

Overview:
Parametrised pseudo-random obstacle generator for the game FSM. It produces a new obstacle code at a programmable rate while the game is in the play state. Compared with the earlier fixed 4-bit generator, this block adds:
- configurable LFSR width, taps and seed;
- a clock-enable tick instead of a derived clock;
- pause, runtime seed loading and a zero-state lock-up guard;
- a valid strobe and a sequence-wrap flag.

It sits between the game state register (`presente`) and the obstacle placement logic.

Parameters:
- WIDTH, 8, LFSR register width (2..32)
- TAPS, 8'hB8, Fibonacci tap mask; bit i set means lfsr[i] feeds the XOR (WIDTH bits)
- SEED, 8'h01, reload value; must be nonzero
- OUT_W, 4, obstacle code width; OUT_W <= WIDTH
- DIVIDER, 71_000_000, clk cycles per LFSR step (>= 2)
- STATE_W, 4, width of game-state input
- PLAY_STATE, 4'd3, `presente` value that enables stepping

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous reset, active-low
- presente  in  STATE_W  current game state
- pause  in  1  freezes stepping and the divider while high
- seed_load  in  1  one-cycle request to load seed_in
- seed_in  in  WIDTH  runtime seed
- obs_aleo  out  OUT_W  obstacle code, = lfsr[OUT_W-1:0]
- obs_valid  out  1  one-cycle pulse in the cycle after each step
- lfsr_state  out  WIDTH  full LFSR register
- wrapped  out  1  one-cycle pulse when the LFSR returns to its last loaded seed

Behaviour:
- Reset (rst=0 at posedge clk):
  - lfsr = SEED, cur_seed = SEED, div_cnt = 0, state = IDLE;
  - obs_valid = 0, wrapped = 0;
  - obs_aleo = SEED[OUT_W-1:0].
  - Reset has priority over every other input.
- Single clock domain. No logic is clocked by a derived signal; the divider produces an internal `tick` enable.
- FSM states:
  - IDLE: entered when presente != PLAY_STATE. lfsr = cur_seed and div_cnt = 0 every cycle.
  - RUN: presente == PLAY_STATE and pause=0. div_cnt increments. When div_cnt == DIVIDER-1: tick=1, div_cnt = 0, and the LFSR steps.
  - HOLD: presente == PLAY_STATE and pause=1. div_cnt and lfsr hold.
  - Transitions are evaluated every cycle from presente and pause:
    - any state -> IDLE when presente != PLAY_STATE;
    - IDLE -> RUN (or HOLD if pause=1) on presente == PLAY_STATE;
    - RUN <-> HOLD follows pause.
- Step rule: lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- Step outputs:
  - obs_valid is registered and high exactly one cycle after the step, so latency from tick to the new obs_aleo is 1 cycle.
  - wrapped is high in the same cycle as obs_valid when lfsr_next == cur_seed.
- Seed load:
  - On seed_load=1, cur_seed = (seed_in == 0) ? SEED : seed_in, and lfsr = that same value.
  - div_cnt is cleared.
  - No obs_valid is produced.
  - seed_load wins over a coincident tick; that step is dropped.
  - It is accepted in any state.
- Lock-up guard: if lfsr is ever 0 (not reachable in normal use, but possible via SEED misuse or SEU), the next cycle loads cur_seed and obs_valid stays 0.
- Leaving RUN mid-count:
  - to HOLD: the partial count is retained;
  - to IDLE: the count is discarded.
- The maximal-length TAPS value gives a period of 2^WIDTH-1 steps. wrapped asserts on step number 2^WIDTH-1 after a load or IDLE exit.

Decomposition:
- Package lfsr_pkg holds:
  - the FSM state enum (IDLE, RUN, HOLD);
  - PLAY_STATE_DEF = 4'd3;
  - the default maximal tap masks per width: 4'h9, 5'h12, 8'hB8, 16'hB400.
- One sub-module, tick_divider (params DIVIDER; ports clk, rst, en, clr, tick), owns div_cnt. It is reused by other timed blocks.

Test Plan:
All scenarios use WIDTH=4, TAPS=4'h9, SEED=4'h1, OUT_W=4, DIVIDER=4.
- Reset: hold rst=0 for 3 cycles, then release with presente=0 -> obs_aleo=1, obs_valid=0, wrapped=0, lfsr_state stays 1.
- Sequence: presente=3 -> obs_valid pulses every 4 clk with obs_aleo = 3, 7, F, E, D, A, 5, B, 6, C, 9, 2, 4, 8, 1. wrapped pulses with the 15th value (1) only.
- Pause: pause=1 after 2 RUN cycles for 10 cycles, then 0 -> no obs_valid during pause; next step occurs 2 cycles after release.
- Game exit: presente 3->2 mid-sequence at value E -> next cycle lfsr_state=1, no obs_valid. Return to 3 -> first value 3 after 4 cycles.
- Seed load:
  - seed_load with seed_in=0 -> lfsr=1 (guard).
  - seed_in=4'hA coinciding with a tick -> lfsr=A, no obs_valid; next step gives 5 after 4 cycles; wrapped fires when A recurs.
- Mid-run reset: rst=0 for one cycle during RUN -> lfsr=1, state IDLE-equivalent, div_cnt=0. The first step after release comes 4 cycles later with value 3.
